// File: rtl/add_accumulator.sv
// add_accumulator: stream adder with group framing; ADD_ACCUMULATOR_SATURATE_EN clamps sum at all-ones.
module add_accumulator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             ovf,
    output logic [7:0]       cnt,
    output logic             out_valid,
    input  logic             out_ready
);
    typedef enum logic {ACCUM, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic ovf_q, ovf_d;
    logic [7:0] cnt_q, cnt_d;
    logic accept, release_out;
    logic [WIDTH:0] add;
    assign accept = in_valid && in_ready;
    assign release_out = out_valid && out_ready;
    assign add = {1'b0, sum_q} + {1'b0, in_data};
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            sum_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            sum_q <= sum_d;
            ovf_q <= ovf_d;
            cnt_q <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        if (state_q == ACCUM && accept && in_last) state_d = DONE;
        if (state_q == DONE && out_ready) state_d = ACCUM;
    end
    always_comb begin
        in_ready = state_q == ACCUM;
        out_valid = state_q == DONE;
    end
    // a carry out of an all-ones sum covers the saturated case too
    always_comb begin
        sum_d = sum_q;
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (accept) begin
`ifdef ADD_ACCUMULATOR_SATURATE_EN
            sum_d = add[WIDTH] ? '1 : add[WIDTH-1:0];
`else
            sum_d = add[WIDTH-1:0];
`endif
            ovf_d = ovf_q | add[WIDTH];
            cnt_d = cnt_q + {7'd0, cnt_q != 8'hff};
        end else if (release_out) begin
            sum_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
        end
    end
    assign sum = sum_q;
    assign ovf = ovf_q;
    assign cnt = cnt_q;
endmodule

// File: doc/add_accumulator.md
ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 Parameter: WIDTH, default 8, operand/sum width in bits.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: in_data  input  WIDTH  operand to add into the running sum.
REQ-005 Port: in_valid  input  1  in_data/in_last valid this cycle.
REQ-006 Port: in_last  input  1  current beat is the final operand of the group.
REQ-007 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-008 Port: sum  output  WIDTH  running/final accumulated sum (registered).
REQ-009 Port: ovf  output  1  sticky carry-out/overflow for the current group.
REQ-010 Port: cnt  output  8  operands accepted in the current group, saturating at 255.
REQ-011 Port: out_valid  output  1  sum/ovf/cnt hold a completed group result.
REQ-012 Port: out_ready  input  1  downstream consumes the result this cycle.

Function
REQ-013 FSM SHALL have two states: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1); outputs are decoded from state only.
REQ-014 Input beat SHALL be accepted iff in_valid=1 and in_ready=1 at a rising edge.
REQ-015 On accept: {cout, sum_next} SHALL equal sum + in_data computed in WIDTH+1 bits; ovf <= ovf | cout; cnt <= cnt+1 unless cnt=255 (then holds).
REQ-016 Sum register SHALL update in the same edge as the accept (1-cycle latency); sum is visible at all times, not only in DONE.
REQ-017 Accept with in_last=1 SHALL move ACCUM->DONE; out_valid asserts the cycle after the last beat is accepted, showing the sum including that beat.
REQ-018 In DONE, sum, ovf, cnt SHALL hold stable while out_ready=0; in_valid/in_data/in_last are ignored.
REQ-019 In DONE with out_ready=1: next edge SHALL clear sum, ovf, cnt to 0 and move to ACCUM.
REQ-020 No accept and no output transfer SHALL ever occur in the same cycle (in_ready and out_valid mutually exclusive).
REQ-021 in_valid=0 in ACCUM SHALL leave all state unchanged; gaps between beats are legal and unbounded.
REQ-022 A group of one beat (first beat has in_last=1) SHALL be legal: result = that operand, cnt=1.

Reset
REQ-023 rst=1 at a rising edge SHALL force state=ACCUM, sum=0, ovf=0, cnt=0, hence in_ready=1, out_valid=0, regardless of current state or inputs.
REQ-024 Reset SHALL take priority over accept and output transfer in the same cycle; a reset mid-group discards the partial sum.

Configuration
REQ-025 Macro ADD_ACCUMULATOR_SATURATE_EN, when defined, SHALL make an accept whose carry-out is 1 (or whose sum is already all-ones with nonzero operand) load sum = all-ones (2^WIDTH-1) and set ovf; sum then stays all-ones until cleared.
REQ-026 Without ADD_ACCUMULATOR_SATURATE_EN, sum SHALL wrap modulo 2^WIDTH; ovf is set identically in both builds.

Verification (WIDTH=8)
REQ-027 Reset: rst=1 two cycles from arbitrary state -> sum=0, ovf=0, cnt=0, in_ready=1, out_valid=0.
REQ-028 Basic group: beats 10, 20, 30(last) back-to-back, out_ready=1 -> out_valid one cycle after third accept, sum=60, ovf=0, cnt=3; next cycle sum=0, in_ready=1.
REQ-029 Overflow: beats 200, 100(last) -> without macro sum=44, ovf=1; with macro sum=255, ovf=1; cnt=2 in both.
REQ-030 Backpressure: hold out_ready=0 five cycles in DONE while driving in_valid=1, in_data=5 -> sum/ovf/cnt unchanged, in_ready=0; raise out_ready -> clear and return to ACCUM next cycle.
REQ-031 Gaps and single beat: beat 7 with in_last=1 after 3 idle cycles -> sum=7, cnt=1, out_valid next cycle.
REQ-032 Reset mid-group: accept 50, 60, then rst=1 with in_valid=1 -> next cycle sum=0, cnt=0, ovf=0, beat not accepted.
